// File: rtl/button_pkg.sv
// Shared constants, channel state type and counter-width helper for the button front end.
package button_pkg;

   localparam int unsigned MsPerSec = 1000;

   typedef enum logic [1:0] {
      StIdle,
      StPressed,
      StLong
   } ch_state_e;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchroniser, tick-based debounce, hold/repeat timing, pulse outputs.
module button_channel
   import button_pkg::*;
#(
   parameter int unsigned STABLE_MS = 10,
   parameter int unsigned LONG_MS   = 1000,
   parameter int unsigned REPEAT_MS = 200
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   input  logic raw_i,
   output logic level_o,
   output logic pressed_o,
   output logic released_o,
   output logic long_o,
   output logic repeat_o
);

   localparam int unsigned DbW   = cnt_width(STABLE_MS);
   localparam int unsigned HoldW = cnt_width(LONG_MS);
   localparam int unsigned RepW  = cnt_width(REPEAT_MS);

   logic [1:0]       sync_q;
   ch_state_e        state_q, state_d;
   logic [DbW-1:0]   db_cnt_q, db_cnt_d;
   logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
   logic [RepW-1:0]  rep_cnt_q, rep_cnt_d;
   logic             level_q, level_d;
   logic             pressed_q, pressed_d;
   logic             released_q, released_d;
   logic             long_q, long_d;
   logic             repeat_q, repeat_d;
   logic             sync;
   logic             accept;

   assign sync   = sync_q[1];
   assign accept = tick_i && (sync != level_q) && (db_cnt_q == DbW'(STABLE_MS - 1));

   always_comb begin
      state_d    = state_q;
      db_cnt_d   = db_cnt_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      level_d    = level_q;
      pressed_d  = 1'b0;
      released_d = 1'b0;
      long_d     = 1'b0;
      repeat_d   = 1'b0;

      if (sync == level_q) begin
         db_cnt_d = '0;
      end else if (tick_i) begin
         db_cnt_d = accept ? '0 : db_cnt_q + DbW'(1);
      end

      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d   = StPressed;
               level_d   = 1'b1;
               pressed_d = 1'b1;
            end
         end
         StPressed, StLong: begin
            // An accepted release outranks a long/repeat terminal count on the same tick.
            if (accept) begin
               state_d    = StIdle;
               level_d    = 1'b0;
               released_d = 1'b1;
               hold_cnt_d = '0;
               rep_cnt_d  = '0;
            end else if (tick_i && state_q == StPressed) begin
               hold_cnt_d = hold_cnt_q + HoldW'(1);
               if (hold_cnt_q == HoldW'(LONG_MS - 1)) begin
                  long_d  = 1'b1;
                  state_d = StLong;
               end
            end else if (tick_i && REPEAT_MS != 0) begin
               if (rep_cnt_q == RepW'(REPEAT_MS - 1)) begin
                  repeat_d  = 1'b1;
                  rep_cnt_d = '0;
               end else begin
                  rep_cnt_d = rep_cnt_q + RepW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q     <= '0;
         state_q    <= StIdle;
         db_cnt_q   <= '0;
         hold_cnt_q <= '0;
         rep_cnt_q  <= '0;
         level_q    <= 1'b0;
         pressed_q  <= 1'b0;
         released_q <= 1'b0;
         long_q     <= 1'b0;
         repeat_q   <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], raw_i};
         state_q    <= state_d;
         db_cnt_q   <= db_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         rep_cnt_q  <= rep_cnt_d;
         level_q    <= level_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
         long_q     <= long_d;
         repeat_q   <= repeat_d;
      end
   end

   assign level_o    = level_q;
   assign pressed_o  = pressed_q;
   assign released_o = released_q;
   assign long_o     = long_q;
   assign repeat_o   = repeat_q;

endmodule

// File: rtl/button_bank.sv
// Multi-channel button front end: shared 1 ms prescaler, polarity select, channel array.
module button_bank
   import button_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned STABLE_MS  = 10,
   parameter int unsigned LONG_MS    = 1000,
   parameter int unsigned REPEAT_MS  = 200,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] btn_raw,
   output logic [NUM_CH-1:0] btn_level,
   output logic [NUM_CH-1:0] btn_pressed,
   output logic [NUM_CH-1:0] btn_released,
   output logic [NUM_CH-1:0] btn_long,
   output logic [NUM_CH-1:0] btn_repeat
);

   localparam int unsigned TICK_DIV = CLK_FREQ / MsPerSec;
   localparam int unsigned DivW     = cnt_width(TICK_DIV - 1);

   logic [DivW-1:0]   div_q, div_d;
   logic              tick;
   logic [NUM_CH-1:0] raw_cond;

   assign tick     = (div_q == DivW'(TICK_DIV - 1));
   assign div_d    = tick ? '0 : div_q + DivW'(1);
   assign raw_cond = ACTIVE_LOW ? ~btn_raw : btn_raw;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      button_channel #(
         .STABLE_MS(STABLE_MS),
         .LONG_MS  (LONG_MS),
         .REPEAT_MS(REPEAT_MS)
      ) u_ch (
         .clk_i     (clk),
         .rst_i     (rst),
         .tick_i    (tick),
         .raw_i     (raw_cond[i]),
         .level_o   (btn_level[i]),
         .pressed_o (btn_pressed[i]),
         .released_o(btn_released[i]),
         .long_o    (btn_long[i]),
         .repeat_o  (btn_repeat[i])
      );
   end

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: debounce latency, bounce rejection, long/repeat, reset, priority.
module tb_button_bank;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn_raw = 4'h0;
   logic [3:0] raw_lo;
   logic [3:0] level, pressed, released, long_p, rep;
   logic [3:0] level_lo, pressed_lo, released_lo, long_lo, rep_lo;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;
   int n_press[4], n_rel[4], n_long[4], n_rep[4];
   int t_press[4], t_rel[4], t_long[4], t_rep[4];
   int t_press_lo[4];

   assign raw_lo = ~btn_raw;

   button_bank #(
      .CLK_FREQ(10_000), .NUM_CH(4), .STABLE_MS(3), .LONG_MS(20), .REPEAT_MS(5), .ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(level), .btn_pressed(pressed),
      .btn_released(released), .btn_long(long_p), .btn_repeat(rep)
   );

   button_bank #(
      .CLK_FREQ(10_000), .NUM_CH(4), .STABLE_MS(3), .LONG_MS(20), .REPEAT_MS(5), .ACTIVE_LOW(1'b1)
   ) dut_lo (
      .clk(clk), .rst(rst), .btn_raw(raw_lo), .btn_level(level_lo), .btn_pressed(pressed_lo),
      .btn_released(released_lo), .btn_long(long_lo), .btn_repeat(rep_lo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Counts cycles each pulse is high, so a stuck pulse shows up as an extra count.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (pressed[i])  begin n_press[i]++; t_press[i] = cyc; end
         if (released[i]) begin n_rel[i]++;   t_rel[i]   = cyc; end
         if (long_p[i])   begin n_long[i]++;  t_long[i]  = cyc; end
         if (rep[i])      begin n_rep[i]++;   t_rep[i]   = cyc; end
         if (pressed_lo[i]) t_press_lo[i] = cyc;
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int t0, tp, d;
   int bp, br, bl, bq;

   initial begin
      // Reset
      step(4);
      check_eq("rst_level", level, 0);
      check_eq("rst_pulses", {pressed, released, long_p, rep}, 0);
      rst = 1'b0;
      step(1);
      check_eq("post_rst_out", {level, pressed, released, long_p, rep}, 0);
      step(20);

      // 1: clean press on ch0
      bp = n_press[0];
      btn_raw[0] = 1'b1;
      t0 = cyc;
      step(100);
      d = t_press[0] - t0;
      check_eq("t1_press_cnt", n_press[0] - bp, 1);
      check_eq("t1_press_lat_in_22_32", int'(d >= 22 && d <= 32), 1);
      check_eq("t1_level", level, 4'b0001);
      br = n_rel[0];
      btn_raw[0] = 1'b0;
      step(40);
      check_eq("t1_rel_cnt", n_rel[0] - br, 1);
      check_eq("t1_level_off", level, 0);

      // 2: bounce on ch1, last toggle leaves it high
      bp = n_press[1];
      for (int k = 0; k < 9; k++) begin
         btn_raw[1] = (k % 2 == 0);
         if (k < 8) step(7);
      end
      t0 = cyc;
      check_eq("t2_no_press_bounce", n_press[1] - bp, 0);
      check_eq("t2_level_bounce", level, 0);
      step(40);
      d = t_press[1] - t0;
      check_eq("t2_press_cnt", n_press[1] - bp, 1);
      check_eq("t2_press_lat_in_22_32", int'(d >= 22 && d <= 32), 1);
      btn_raw[1] = 1'b0;
      step(40);

      // 3: long press and repeat on ch2; 4th repeat coincides with release and is dropped
      bp = n_press[2]; bl = n_long[2]; bq = n_rep[2]; br = n_rel[2];
      btn_raw[2] = 1'b1;
      step(400);
      btn_raw[2] = 1'b0;
      step(40);
      check_eq("t3_press_cnt", n_press[2] - bp, 1);
      check_eq("t3_long_cnt", n_long[2] - bl, 1);
      check_eq("t3_long_delay", t_long[2] - t_press[2], 200);
      check_eq("t3_rep_cnt", n_rep[2] - bq, 3);
      check_eq("t3_last_rep_delay", t_rep[2] - t_long[2], 150);
      check_eq("t3_rel_cnt", n_rel[2] - br, 1);
      check_eq("t3_rel_delay", t_rel[2] - t_press[2], 400);

      // 4: all channels at once, plus active-low instance
      check_eq("t4_lo_idle", level_lo, 0);
      bp = n_press[0] + n_press[1] + n_press[2] + n_press[3];
      btn_raw = 4'hF;
      step(40);
      check_eq("t4_press_total", n_press[0] + n_press[1] + n_press[2] + n_press[3] - bp, 4);
      for (int i = 1; i < 4; i++) check_eq($sformatf("t4_same_cycle_ch%0d", i), t_press[i], t_press[0]);
      check_eq("t4_level", level, 4'hF);
      check_eq("t4_lo_level", level_lo, 4'hF);
      check_eq("t4_lo_same_cycle", t_press_lo[0], t_press[0]);

      // 5: reset mid-hold, buttons kept held
      br = n_rel[3]; bp = n_press[3];
      rst = 1'b1;
      step(1);
      check_eq("t5_rst_out", {level, pressed, released, long_p, rep}, 0);
      step(2);
      rst = 1'b0;
      step(1);
      check_eq("t5_post_rst_out", {level, pressed, released, long_p, rep}, 0);
      step(40);
      check_eq("t5_no_release", n_rel[3] - br, 0);
      check_eq("t5_fresh_press", n_press[3] - bp, 1);
      check_eq("t5_level", level, 4'hF);
      btn_raw = 4'h0;
      step(40);
      check_eq("t5_level_off", level, 0);

      // 6: release accepted on the LONG_MS tick
      bp = n_press[0]; bl = n_long[0]; br = n_rel[0];
      btn_raw[0] = 1'b1;
      for (int k = 0; k < 60 && n_press[0] == bp; k++) step(1);
      check_eq("t6_press_seen", n_press[0] - bp, 1);
      if (n_press[0] != bp) begin
         tp = t_press[0];
         while (cyc < tp + 175) step(1);
         btn_raw[0] = 1'b0;
         step(60);
         check_eq("t6_no_long", n_long[0] - bl, 0);
         check_eq("t6_rel_cnt", n_rel[0] - br, 1);
         check_eq("t6_rel_at_long_tick", t_rel[0] - tp, 200);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
